ebi_xfer_engine: RTL

EBI_XFER_ENGINE -- requirements
Module: ebi_xfer_engine

---
 rtl/ebi_xfer_engine.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ebi_xfer_engine.sv
// ebi_xfer_engine: moves one cache line at a time between N_CH requesters and a
// shared, time-multiplexed external bus.
// Optional build macro EBI_XFER_TIMEOUT_EN adds a response watchdog. When it fires,
// the engine returns an error beat instead of waiting forever for a response marker.
//
// Handshakes: a transfer on req_*, w* or r* happens on a rising edge where valid and
// ready are both 1. valid does not wait for ready. A valid payload stays stable until
// it is accepted.
module ebi_xfer_engine #(
    parameter int EBI_WIDTH      = 16,
    parameter int PADDR_WIDTH    = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int LINE_BEATS     = 8,
    parameter int N_CH           = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CW            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CH-1:0]             req_valid_i,
    output logic [N_CH-1:0]             req_ready_o,
    input  logic [N_CH-1:0]             req_write_i,
    input  logic [N_CH*PADDR_WIDTH-1:0] req_addr_i,
    input  logic [N_CH-1:0]             wvalid_i,
    output logic [N_CH-1:0]             wready_o,
    input  logic [N_CH*DATA_WIDTH-1:0]  wdata_i,
    output logic                        rvalid_o,
    input  logic                        rready_i,
    output logic [CW-1:0]               rid_o,
    output logic [DATA_WIDTH-1:0]       rdata_o,
    output logic                        rlast_o,
    output logic                        rerr_o,
    input  logic [EBI_WIDTH-1:0]        ebi_i,
    output logic [EBI_WIDTH-1:0]        ebi_o,
    output logic [EBI_WIDTH-1:0]        ebi_oen,
    output logic                        bus_switch_o,
    input  logic                        bus_switch_i
);
    localparam int ADDR_BEATS = (PADDR_WIDTH + EBI_WIDTH - 1) / EBI_WIDTH;
    localparam int ADDR_PAD   = ADDR_BEATS * EBI_WIDTH;
    localparam int LINE_BITS  = LINE_BEATS * DATA_WIDTH;
    localparam int LINE_EBI   = LINE_BITS / EBI_WIDTH;
    localparam int HDR_BEATS  = ADDR_BEATS + 2;   // opcode + address + id
    localparam int FRAME_MAX  = HDR_BEATS + LINE_EBI;
    localparam int CNT_W      = $clog2(FRAME_MAX + 1);

    typedef enum logic [2:0] {IDLE, WFILL, ACQ, SEND, WAIT, RECV, RESP, ERR} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]          ch_q, ch_d;
    logic                   write_q, write_d;
    logic [PADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic                   ack_err_q, ack_err_d;

    logic                   grant_found;
    logic [CW-1:0]          grant_ch;
    logic [ADDR_PAD-1:0]    addr_ext;

    assign addr_ext = ADDR_PAD'(addr_q);

`ifdef EBI_XFER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Watchdog counts cycles spent in WAIT and restarts from zero on every entry.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == WAIT) to_cnt_d = to_cnt_q + 1'b1;
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    // Without the watchdog the wait limit has no effect; keep it referenced.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Round-robin search starting at the pointer; first valid channel wins.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_ch    = '0;
        idx         = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!grant_found && req_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_ch    = CW'(idx);
            end
        end
    end

    // Next-state and output decode; every output is forced idle while rst is high.
    always_comb begin
        int beat;
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        ch_d      = ch_q;
        write_d   = write_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        ack_err_d = ack_err_q;
        beat      = int'(cnt_q);

        req_ready_o  = '0;
        wready_o     = '0;
        rvalid_o     = 1'b0;
        rid_o        = ch_q;
        rdata_o      = '0;
        rlast_o      = 1'b0;
        rerr_o       = 1'b0;
        ebi_o        = '0;
        ebi_oen      = '1;
        bus_switch_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready_o[grant_ch] = 1'b1;
                    ch_d    = grant_ch;
                    write_d = req_write_i[grant_ch];
                    addr_d  = req_addr_i[int'(grant_ch)*PADDR_WIDTH +: PADDR_WIDTH];
                    cnt_d   = '0;
                    if (int'(grant_ch) == N_CH - 1) rr_ptr_d = '0;
                    else                            rr_ptr_d = grant_ch + 1'b1;
                    state_d = req_write_i[grant_ch] ? WFILL : ACQ;
                end
            end
            WFILL: begin
                wready_o[ch_q] = 1'b1;
                if (wvalid_i[ch_q]) begin
                    line_d[beat*DATA_WIDTH +: DATA_WIDTH] =
                        wdata_i[int'(ch_q)*DATA_WIDTH +: DATA_WIDTH];
                    if (beat == LINE_BEATS - 1) begin
                        cnt_d   = '0;
                        state_d = ACQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ACQ: begin
                bus_switch_o = 1'b1;
                if (bus_switch_i) begin
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                bus_switch_o = 1'b1;
                ebi_oen      = '0;
                if (beat == 0)                ebi_o = EBI_WIDTH'(write_q);
                else if (beat <= ADDR_BEATS)  ebi_o = addr_ext[(beat-1)*EBI_WIDTH +: EBI_WIDTH];
                else if (beat == HDR_BEATS-1) ebi_o = EBI_WIDTH'(ch_q);
                else                          ebi_o = line_q[(beat-HDR_BEATS)*EBI_WIDTH +: EBI_WIDTH];
                if (beat == (write_q ? FRAME_MAX : HDR_BEATS) - 1) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                bus_switch_o = 1'b1;
                if (ebi_i == '1) begin
                    cnt_d   = '0;
                    state_d = RECV;
                end
`ifdef EBI_XFER_TIMEOUT_EN
                else if (int'(to_cnt_q) == TIMEOUT_CYCLES - 1) begin
                    state_d = ERR;
                end
`endif
            end
            RECV: begin
                bus_switch_o = 1'b1;
                if (write_q) begin
                    ack_err_d = |ebi_i;
                    cnt_d     = '0;
                    state_d   = RESP;
                end else begin
                    line_d[beat*EBI_WIDTH +: EBI_WIDTH] = ebi_i;
                    if (beat == LINE_EBI - 1) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESP: begin
                bus_switch_o = 1'b1;
                rvalid_o     = 1'b1;
                if (write_q) begin
                    rlast_o = 1'b1;
                    rerr_o  = ack_err_q;
                    if (rready_i) state_d = IDLE;
                end else begin
                    rdata_o = line_q[beat*DATA_WIDTH +: DATA_WIDTH];
                    rlast_o = (beat == LINE_BEATS - 1);
                    if (rready_i) begin
                        if (beat == LINE_BEATS - 1) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            ERR: begin
                bus_switch_o = 1'b1;
                rvalid_o     = 1'b1;
                rlast_o      = 1'b1;
                rerr_o       = 1'b1;
                if (rready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            req_ready_o  = '0;
            wready_o     = '0;
            rvalid_o     = 1'b0;
            rid_o        = '0;
            rdata_o      = '0;
            rlast_o      = 1'b0;
            rerr_o       = 1'b0;
            ebi_o        = '0;
            ebi_oen      = '1;
            bus_switch_o = 1'b0;
        end
    end

    // State, request latch, line buffer and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            ch_q      <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            line_q    <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            ch_q      <= ch_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            ack_err_q <= ack_err_d;
        end
    end
endmodule
